// File: rtl/irq_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller_pkg
// Brief    : Register map, FSM state encoding and STATUS layout shared by the
//            interrupt controller sources.
// Revision : 1.0 - initial release
// ============================================================================
package irq_controller_pkg;

    localparam logic [1:0] IRQC_PEND   = 2'd0;
    localparam logic [1:0] IRQC_MASK   = 2'd1;
    localparam logic [1:0] IRQC_CTRL   = 2'd2;
    localparam logic [1:0] IRQC_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    localparam int STATUS_IRQ_BIT   = 31;
    localparam int STATUS_INSVC_BIT = 30;
    localparam int STATUS_ID_MSB    = 2;
    localparam int STATUS_ID_LSB    = 0;

    function automatic logic [31:0] status_word(input logic       irq,
                                                input logic       in_service,
                                                input logic [2:0] id);
        logic [31:0] word;
        word                                = '0;
        word[STATUS_IRQ_BIT]                = irq;
        word[STATUS_INSVC_BIT]              = in_service;
        word[STATUS_ID_MSB:STATUS_ID_LSB]   = id;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller_if
// Brief    : Bus, peripheral request and CPU handshake signals of the
//            interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_controller_if #(
    parameter int NUM_SRC = 4
);
    logic               MemWrite;
    logic [1:0]         address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic [NUM_SRC-1:0] irq_src;
    logic               cpu_ack;
    logic               cpu_eret;
    logic               cpu_irq;
    logic [2:0]         irq_id;

    modport slave (
        input  MemWrite, address, write_data, irq_src, cpu_ack, cpu_eret,
        output read_data, cpu_irq, irq_id
    );

    modport master (
        output MemWrite, address, write_data, irq_src, cpu_ack, cpu_eret,
        input  read_data, cpu_irq, irq_id
    );
endinterface
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Brief    : Combinational priority encoder; the lowest set index wins.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [2:0]         id
);

    // Scanning downwards lets the lowest set index overwrite the others.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[k]) begin
                valid = 1'b1;
                id    = 3'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Pending/mask/enable interrupt controller with a registered CPU
//            request and ack/eret handshake. Define IRQ_CTRL_EDGE_EN for
//            rising-edge capture; the default build is level-sensitive.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic           clk,
    input  logic           reset,
    irq_controller_if.slave bus
);

    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] mask_q;
    logic               ge_q;
    irq_state_t         state_q;
    irq_state_t         state_d;
    logic               cpu_irq_q;
    logic [2:0]         irq_id_q;
    logic [2:0]         irq_id_d;

    logic [NUM_SRC-1:0] src_event;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] wr_clr;
    logic [NUM_SRC-1:0] ack_clr;
    logic [7:0]         pend_ext;
    logic [7:0]         mask_ext;
    logic               cur_pend;
    logic               cur_mask;
    logic               ack_take;
    logic               win_valid;
    logic [2:0]         win_id;
    logic               unused_wdata;

    assign unused_wdata = ^bus.write_data;

`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] src_hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            src_hist_q <= '0;
        end else begin
            src_hist_q <= bus.irq_src;
        end
    end

    assign src_event = bus.irq_src & ~src_hist_q;
`else
    assign src_event = bus.irq_src;
`endif

    always_comb begin
        pend_ext                = '0;
        mask_ext                = '0;
        pend_ext[NUM_SRC-1:0]   = pend_q;
        mask_ext[NUM_SRC-1:0]   = mask_q;
    end

    assign cur_pend = pend_ext[irq_id_q];
    assign cur_mask = mask_ext[irq_id_q];
    assign eligible = ge_q ? (pend_q & mask_q) : '0;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .req     (eligible),
        .valid   (win_valid),
        .id      (win_id)
    );

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d  = ST_REQ;
                    irq_id_d = win_id;
                end
            end
            ST_REQ: begin
                // An ack wins over a same-cycle withdrawal: the CPU already saw cpu_irq high.
                if (bus.cpu_ack) begin
                    state_d  = ST_SERVICE;
                    ack_take = 1'b1;
                end else if (!ge_q || !cur_mask || !cur_pend) begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.cpu_eret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_clr  = '0;
        ack_clr = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            wr_clr[k]  = bus.MemWrite && (bus.address == IRQC_PEND) && bus.write_data[k];
            ack_clr[k] = ack_take && (irq_id_q == 3'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= '0;
            mask_q    <= '0;
            ge_q      <= 1'b0;
            state_q   <= ST_IDLE;
            cpu_irq_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            // New events are OR-ed in last so a set beats any clear.
            pend_q <= (pend_q & ~wr_clr & ~ack_clr) | src_event;
            if (bus.MemWrite && (bus.address == IRQC_MASK)) begin
                mask_q <= bus.write_data[NUM_SRC-1:0];
            end
            if (bus.MemWrite && (bus.address == IRQC_CTRL)) begin
                ge_q <= bus.write_data[0];
            end
            state_q   <= state_d;
            cpu_irq_q <= (state_d == ST_REQ);
            irq_id_q  <= irq_id_d;
        end
    end

    always_comb begin
        bus.read_data = '0;
        case (bus.address)
            IRQC_PEND:   bus.read_data[NUM_SRC-1:0] = pend_q;
            IRQC_MASK:   bus.read_data[NUM_SRC-1:0] = mask_q;
            IRQC_CTRL:   bus.read_data[0]           = ge_q;
            IRQC_STATUS: bus.read_data = status_word(cpu_irq_q, state_q == ST_SERVICE, irq_id_q);
            default:     bus.read_data = '0;
        endcase
    end

    assign bus.cpu_irq = cpu_irq_q;
    assign bus.irq_id  = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Directed scenarios plus randomized traffic against a behavioural
//            model of the interrupt controller (honours IRQ_CTRL_EDGE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    localparam int         NS   = 4;
    localparam logic [7:0] FULL = 8'((1 << NS) - 1);

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic chk_en;

    irq_controller_if #(.NUM_SRC(NS)) bus_if();

    irq_controller #(
        .NUM_SRC (NS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 = nothing raised, 1 = request outstanding, 2 = handler running.
    logic [7:0] m_pend, m_mask, m_hist;
    logic       m_ge;
    int         m_phase;
    logic [2:0] m_id;

    always @(posedge clk) begin : model
        logic [7:0] src, ev, elig, ackclr, wrclr;
        int         win;
        src = 8'(bus_if.irq_src);
`ifdef IRQ_CTRL_EDGE_EN
        ev = src & ~m_hist;
`else
        ev = src;
`endif
        m_hist = src;
        if (reset) begin
            m_pend = 8'h0; m_mask = 8'h0; m_ge = 1'b0; m_hist = 8'h0;
            m_phase = 0; m_id = 3'd0;
        end else begin
            elig   = m_ge ? (m_pend & m_mask) : 8'h0;
            ackclr = 8'h0;
            win    = -1;
            for (int i = 0; i < NS; i++) begin
                if (elig[i] && win < 0) win = i;
            end
            if (m_phase == 0) begin
                if (win >= 0) begin m_phase = 1; m_id = 3'(win); end
            end else if (m_phase == 1) begin
                if (bus_if.cpu_ack) begin
                    m_phase = 2;
                    ackclr  = 8'h1 << m_id;
                end else if (!m_ge || !m_mask[m_id] || !m_pend[m_id]) begin
                    m_phase = 0;
                end
            end else if (bus_if.cpu_eret) begin
                m_phase = 0;
            end
            wrclr  = (bus_if.MemWrite && bus_if.address == 2'd0) ? bus_if.write_data[7:0] : 8'h0;
            m_pend = ((m_pend & ~wrclr & ~ackclr) | ev) & FULL;
            if (bus_if.MemWrite && bus_if.address == 2'd1) m_mask = bus_if.write_data[7:0] & FULL;
            if (bus_if.MemWrite && bus_if.address == 2'd2) m_ge = bus_if.write_data[0];
        end
    end

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_pend};
            2'd1:    return {24'h0, m_mask};
            2'd2:    return {31'h0, m_ge};
            default: return {(m_phase == 1), (m_phase == 2), 27'h0, m_id};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_cpu_irq", {31'h0, bus_if.cpu_irq}, {31'h0, (m_phase == 1)});
            chk("model_irq_id", {29'h0, bus_if.irq_id}, {29'h0, m_id});
            chk("model_read_data", bus_if.read_data, m_read(bus_if.address));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.MemWrite = 1'b1; bus_if.address = a; bus_if.write_data = d;
        cyc();
        bus_if.MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string name, input logic [31:0] exp);
        bus_if.address = a;
        #1;
        chk(name, bus_if.read_data, exp);
    endtask

    task automatic pulse_ack();
        bus_if.cpu_ack = 1'b1; cyc(); bus_if.cpu_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        bus_if.cpu_eret = 1'b1; cyc(); bus_if.cpu_eret = 1'b0;
    endtask

    initial begin
        int nreq;
        logic prev_irq;
        checks = 0; errors = 0; chk_en = 1'b0;
        reset = 1'b1;
        bus_if.MemWrite = 1'b0; bus_if.address = 2'd0; bus_if.write_data = '0;
        bus_if.irq_src = '0; bus_if.cpu_ack = 1'b0; bus_if.cpu_eret = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;

        // Reset state
        chk("rst_cpu_irq", {31'h0, bus_if.cpu_irq}, 32'h0);
        rd(2'd0, "rst_pend", 32'h0);
        rd(2'd1, "rst_mask", 32'h0);
        rd(2'd3, "rst_status", 32'h0);

        // Timer event to CPU request, then ack and return
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h1);
        bus_if.irq_src = 4'b0001; cyc(); bus_if.irq_src = '0;
        rd(2'd0, "timer_pend_set", 32'h1);
        chk("timer_no_irq_yet", {31'h0, bus_if.cpu_irq}, 32'h0);
        cyc();
        chk("timer_irq", {31'h0, bus_if.cpu_irq}, 32'h1);
        chk("timer_id", {29'h0, bus_if.irq_id}, 32'h0);
        cyc();
        pulse_ack();
        chk("ack_irq_low", {31'h0, bus_if.cpu_irq}, 32'h0);
        rd(2'd0, "ack_pend_clr", 32'h0);
        rd(2'd3, "ack_status", 32'h4000_0000);
        pulse_eret();
        rd(2'd3, "eret_status", 32'h0);

        // Priority and return
        wr(2'd1, 32'hF);
        bus_if.irq_src = 4'b0110; cyc(); bus_if.irq_src = '0;
        cyc();
        chk("prio_id1", {29'h0, bus_if.irq_id}, 32'h1);
        pulse_ack();
        rd(2'd3, "prio_svc1", 32'h4000_0001);
        pulse_eret();
        chk("prio_idle_after_eret", {31'h0, bus_if.cpu_irq}, 32'h0);
        cyc();
        rd(2'd3, "prio_req2", 32'h8000_0002);
        pulse_ack();
        pulse_eret();

        // Masking withdraws a raised request
        bus_if.irq_src = 4'b1000; cyc(); bus_if.irq_src = '0;
        cyc();
        rd(2'd3, "mask_req3", 32'h8000_0003);
        wr(2'd1, 32'h7);
        cyc();
        chk("mask_irq_drop", {31'h0, bus_if.cpu_irq}, 32'h0);
        rd(2'd0, "mask_pend3_kept", 32'h8);
        rd(2'd3, "mask_status_idle", 32'h3);
        wr(2'd0, 32'h8);
        wr(2'd1, 32'hF);

        // Write-1-clear colliding with a set
        bus_if.irq_src = 4'b0010;
        bus_if.MemWrite = 1'b1; bus_if.address = 2'd0; bus_if.write_data = 32'h2;
        cyc();
        bus_if.irq_src = '0; bus_if.MemWrite = 1'b0;
        rd(2'd0, "w1c_set_wins", 32'h2);
        cyc();
        pulse_ack();
        pulse_eret();

        // Held-high timer with an auto-responding handler
        nreq = 0; prev_irq = 1'b0;
        for (int i = 0; i < 26; i++) begin
            bus_if.irq_src  = (i < 20) ? 4'b0001 : 4'b0000;
            bus_if.address  = 2'd3;
            #1;
            bus_if.cpu_ack  = bus_if.cpu_irq;
            bus_if.cpu_eret = bus_if.read_data[30];
            cyc();
            if (bus_if.cpu_irq && !prev_irq) nreq++;
            prev_irq = bus_if.cpu_irq;
        end
        bus_if.cpu_ack = 1'b0; bus_if.cpu_eret = 1'b0;
`ifdef IRQ_CTRL_EDGE_EN
        chk("held_request_count", 32'(nreq), 32'd1);
`else
        chk("held_request_count", 32'(nreq), 32'd7);
`endif

        // Reset while servicing with PEND=0x5
        bus_if.irq_src = 4'b0101; cyc();
        cyc();
        pulse_ack();
        bus_if.irq_src = 4'b0000; cyc();
        bus_if.irq_src = 4'b0001; cyc();
        bus_if.irq_src = 4'b0000;
        rd(2'd0, "svc_pend5", 32'h5);
        rd(2'd3, "svc_status", 32'h4000_0000);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst_mid_irq", {31'h0, bus_if.cpu_irq}, 32'h0);
        rd(2'd0, "rst_mid_pend", 32'h0);
        rd(2'd1, "rst_mid_mask", 32'h0);
        rd(2'd2, "rst_mid_ctrl", 32'h0);
        rd(2'd3, "rst_mid_status", 32'h0);
        pulse_eret();
        rd(2'd3, "rst_eret_ignored", 32'h0);

        // Randomized traffic, checked every cycle by the model compare
        for (int i = 0; i < 4000; i++) begin
            reset              = ($urandom_range(399) == 0);
            bus_if.irq_src     = 4'($urandom) & 4'($urandom) & 4'($urandom);
            bus_if.MemWrite    = ($urandom_range(4) == 0);
            bus_if.address     = 2'($urandom);
            bus_if.write_data  = $urandom;
            if (bus_if.address == 2'd2) bus_if.write_data[0] = ($urandom_range(3) != 0);
            bus_if.cpu_ack     = bus_if.cpu_irq ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            bus_if.cpu_eret    = ($urandom_range(4) == 0);
            cyc();
        end
        reset = 1'b0; bus_if.MemWrite = 1'b0; bus_if.cpu_ack = 1'b0; bus_if.cpu_eret = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller that sits directly downstream of the timer and the other peripheral IRQ lines. It latches requests into a pending register and applies a per-source mask and a global enable. It selects the highest-priority request and drives a single registered interrupt request into the pipeline CPU's exception logic. A request/acknowledge/return handshake with the CPU prevents re-entry while a handler runs.

## Interface
- NUM_SRC, 4: number of IRQ sources, 1..8; source 0 is the timer and has the highest priority.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  bus write strobe; already qualified by the address decoder for this block.
- address  in  2  register select: 0 PEND, 1 MASK, 2 CTRL, 3 STATUS.
- write_data  in  32  bus write data.
- read_data  out  32  combinational read of the selected register.
- irq_src  in  NUM_SRC  raw request lines from peripherals; bit 0 connects to the timer IRQ.
- cpu_ack  in  1  one-cycle pulse from the CPU when it takes the interrupt exception.
- cpu_eret  in  1  one-cycle pulse from the CPU when the handler executes eret.
- cpu_irq  out  1  registered interrupt request to the CPU.
- irq_id  out  3  index of the source being requested or serviced.

## Operation
- PEND[NUM_SRC-1:0]: bit k sets on a qualifying event on irq_src[k] (see Configuration).
  - Writing 1 clears that bit; writing 0 has no effect.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- MASK[NUM_SRC-1:0]: 1 enables the source. Read/write.
- CTRL[0]: global enable (GE). Read/write. Other bits read as 0.
- STATUS: read-only; writes are ignored.
  - [31] cpu_irq
  - [30] in_service
  - [2:0] irq_id
  - all other bits 0
- Unused upper bits of PEND and MASK read as 0.
- Eligible vector = PEND & MASK, gated by GE. The winner is the lowest eligible index.
- FSM states are IDLE, REQ and SERVICE.
  - IDLE → REQ when the eligible vector is nonzero. irq_id latches the winner on this transition. cpu_irq is 1 exactly while in REQ.
  - REQ → SERVICE on cpu_ack. The PEND bit for irq_id is cleared by hardware in the same edge.
  - REQ → IDLE without ack if GE becomes 0, or if MASK or PEND for irq_id becomes 0. cpu_irq drops and irq_id holds its value.
  - SERVICE → IDLE on cpu_eret. A new request can then be raised on the following edge.
- Ignored inputs:
  - cpu_ack outside REQ.
  - cpu_eret outside SERVICE.
  - A higher-priority source arriving while in REQ; irq_id stays frozen until the next IDLE→REQ transition.
- in_service = (state == SERVICE).

## Timing
- Reset values:
  - PEND, MASK and CTRL = 0.
  - state = IDLE.
  - cpu_irq = 0, irq_id = 0.
  - Edge-history register = 0.
- Reset takes priority over every other input, including a reset in the middle of REQ or SERVICE.
- An irq_src event sampled at edge N sets PEND at edge N. The FSM enters REQ at edge N+1, so cpu_irq is high after edge N+1 (2-cycle latency).
- cpu_ack sampled at edge M: cpu_irq is low and PEND[irq_id] is clear after edge M.
- A bus write at edge N is visible on read_data after edge N. It affects FSM eligibility starting at edge N+1.

## Configuration
- IRQ_CTRL_EDGE_EN defined:
  - A PEND bit sets on a rising edge of irq_src[k], detected against a 1-cycle history register.
  - A source held high sets its PEND bit only once.
  - Because the history register resets to 0, a source that is already high when reset is released counts as an edge.
- IRQ_CTRL_EDGE_EN undefined:
  - Level-sensitive: PEND[k] sets on every cycle that irq_src[k]=1.
  - The history register is not built.

## Structure
- Shared package holds:
  - the register address constants (IRQC_PEND=0, IRQC_MASK=1, IRQC_CTRL=2, IRQC_STATUS=3);
  - the FSM state encoding (2-bit: IDLE, REQ, SERVICE);
  - the STATUS bit positions.
- One sub-module: irq_prio_enc, a combinational lowest-index priority encoder with outputs valid and id.

## Test plan
- Timer IRQ edge to CPU request:
  - Stimulus: build with IRQ_CTRL_EDGE_EN, MASK=1, CTRL=1, irq_src[0] rises at edge 10.
  - Required: PEND=1 after edge 10; cpu_irq=1 and irq_id=0 after edge 11.
  - Then ack at edge 13: cpu_irq=0, PEND=0, STATUS[30]=1.
- Priority and return:
  - Stimulus: irq_src[2] and irq_src[1] rise together with MASK=0xF and GE=1.
  - Required: irq_id=1 is serviced first; after cpu_eret, REQ with irq_id=2 follows 1 cycle later.
- Masking and withdrawal:
  - Stimulus: in REQ for source 3, write MASK=0x7.
  - Required: cpu_irq=0 after the next edge, PEND[3] still 1, state IDLE.
- Write-1-clear against a simultaneous set:
  - Stimulus: write PEND=0x2 in the same cycle irq_src[1] rises.
  - Required: PEND[1]=1 afterwards.
- Held-high source:
  - Stimulus: irq_src[0] held high for 20 cycles; handler acks and erets.
  - Required with edge build: exactly one request.
  - Required with level build: a new request 1 cycle after eret.
- Reset mid-service:
  - Stimulus: assert reset while in SERVICE with PEND=0x5.
  - Required after the reset edge: cpu_irq=0, all registers 0, STATUS=0; cpu_eret is subsequently ignored.
